// File: rtl/lsu_pkg.sv
// Shared LSU crossbar definitions: access size encoding, FSM state encoding
// and the default cacheable address window.
package lsu_pkg;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2,
      SZ_D = 2'd3
   } lsu_size_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_CACHE    = 3'd1,
      ST_DEV_REQ  = 3'd2,
      ST_DEV_RESP = 3'd3,
      ST_RESP     = 3'd4
   } lsu_state_e;

   localparam logic [31:0] DEF_CACHE_BASE  = 32'h8000_0000;
   localparam logic [31:0] DEF_CACHE_LIMIT = 32'h87FF_FFFF;

   // Low address bits that must be zero for a naturally aligned access.
   function automatic logic [2:0] size_align_mask(input logic [1:0] size);
      case (size)
         SZ_B:    return 3'b000;
         SZ_H:    return 3'b001;
         SZ_W:    return 3'b011;
         default: return 3'b111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_xbar_if.sv
// Request/response bus between a load/store unit (master) and lsu_xbar (slave).
// Handshake: a request transfers on a rising edge where req_valid and req_ready
// are both high; the master holds its request fields stable while req_valid is
// high and req_ready is low. resp_valid is a single-cycle completion pulse with
// no back-pressure.
interface lsu_xbar_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
);
   logic                  req_valid;
   logic                  req_ready;
   logic                  req_wen;
   logic [ADDR_WIDTH-1:0] req_addr;
   logic [1:0]            req_size;
   logic                  req_unsigned;
   logic [DATA_WIDTH-1:0] req_wdata;
   logic                  resp_valid;
   logic [DATA_WIDTH-1:0] resp_rdata;
   logic                  resp_err;

   modport master (
      output req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_size, req_unsigned, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: store data shift and byte mask generation,
// load data shift followed by sign/zero extension.
module lsu_align
   import lsu_pkg::*;
#(
   parameter  int DATA_WIDTH = 64,
   localparam int STRB       = DATA_WIDTH / 8,
   localparam int OFFW       = $clog2(STRB)
) (
   input  logic [OFFW-1:0]       off,
   input  logic [1:0]            size,
   input  logic                  is_unsigned,
   input  logic [DATA_WIDTH-1:0] st_data,
   output logic [DATA_WIDTH-1:0] st_wdata,
   output logic [STRB-1:0]       st_wmask,
   input  logic [DATA_WIDTH-1:0] ld_data,
   output logic [DATA_WIDTH-1:0] ld_rdata
);

   logic [7:0]            base_mask;
   logic [15:0]           mask_wide;
   logic [DATA_WIDTH-1:0] shifted;
   logic [DATA_WIDTH-1:0] low_mask;
   logic [DATA_WIDTH-1:0] top_bit;
   logic                  sign;

   always_comb begin
      base_mask = 8'h00;
      low_mask  = '1;
      case (size)
         SZ_B: begin
            base_mask = 8'h01;
            low_mask  = DATA_WIDTH'(8'hFF);
         end
         SZ_H: begin
            base_mask = 8'h03;
            low_mask  = DATA_WIDTH'(16'hFFFF);
         end
         SZ_W: begin
            base_mask = 8'h0F;
            low_mask  = DATA_WIDTH'(32'hFFFF_FFFF);
         end
         default: begin
            base_mask = 8'hFF;
            low_mask  = '1;
         end
      endcase

      // Bytes pushed past the top lane fall off here, which truncates
      // accesses that straddle the word boundary.
      mask_wide = {8'h00, base_mask} << off;
      st_wmask  = mask_wide[STRB-1:0];
      st_wdata  = st_data << {off, 3'b000};

      // Full-width accesses have an all-ones low_mask, so ~low_mask is zero
      // and no extension is applied.
      shifted  = ld_data >> {off, 3'b000};
      top_bit  = (low_mask >> 1) + DATA_WIDTH'(1);
      sign     = ~is_unsigned & (|(shifted & top_bit));
      ld_rdata = (shifted & low_mask) | (sign ? ~low_mask : '0);
   end

endmodule

// File: rtl/lsu_xbar.sv
// Routes one load/store at a time to the cache port or the device port by
// address window. Optional LSU_MISALIGN_CHECK_EN rejects misaligned accesses.
module lsu_xbar
   import lsu_pkg::*;
#(
   parameter  int          ADDR_WIDTH  = 64,
   parameter  int          DATA_WIDTH  = 64,
   parameter  logic [31:0] CACHE_BASE  = DEF_CACHE_BASE,
   parameter  logic [31:0] CACHE_LIMIT = DEF_CACHE_LIMIT,
   localparam int          STRB        = DATA_WIDTH / 8,
   localparam int          OFFW        = $clog2(STRB)
) (
   input  logic                  clk,
   input  logic                  rst,
   lsu_xbar_if.slave             bus,
   output logic                  c_valid,
   output logic                  c_wen,
   output logic [31:0]           c_addr,
   output logic [DATA_WIDTH-1:0] c_wdata,
   output logic [STRB-1:0]       c_wmask,
   input  logic [DATA_WIDTH-1:0] c_rdata,
   input  logic                  c_done,
   output logic                  d_req_valid,
   input  logic                  d_req_ready,
   output logic                  d_wen,
   output logic [31:0]           d_addr,
   output logic [DATA_WIDTH-1:0] d_wdata,
   output logic [STRB-1:0]       d_wmask,
   input  logic                  d_resp_valid,
   input  logic [DATA_WIDTH-1:0] d_rdata,
   input  logic                  d_resp_err,
   output logic [2:0]            dbg_state
);

   localparam logic [2:0] IDLE     = ST_IDLE;
   localparam logic [2:0] CACHE    = ST_CACHE;
   localparam logic [2:0] DEV_REQ  = ST_DEV_REQ;
   localparam logic [2:0] DEV_RESP = ST_DEV_RESP;
   localparam logic [2:0] RESP     = ST_RESP;

   logic [2:0]            state;
   logic [31:0]           addr_q;
   logic [1:0]            size_q;
   logic                  uns_q;
   logic                  wen_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;
   logic                  bypass_q;

   logic                  accept;
   logic                  in_cache;
   logic                  misaligned;
   logic                  bad_size;
   logic [DATA_WIDTH-1:0] st_wdata;
   logic [STRB-1:0]       st_wmask;
   logic [DATA_WIDTH-1:0] ld_rdata;

   assign bus.req_ready = (state == IDLE);
   assign accept        = bus.req_valid & bus.req_ready;
   assign in_cache      = (bus.req_addr[31:0] >= CACHE_BASE) &&
                          (bus.req_addr[31:0] <= CACHE_LIMIT);
   assign bad_size      = (DATA_WIDTH == 32) && (bus.req_size == SZ_D);

`ifdef LSU_MISALIGN_CHECK_EN
   assign misaligned = |(bus.req_addr[2:0] & size_align_mask(bus.req_size));
`else
   assign misaligned = 1'b0;
`endif

   lsu_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
      .off         (addr_q[OFFW-1:0]),
      .size        (size_q),
      .is_unsigned (uns_q),
      .st_data     (wdata_q),
      .st_wdata    (st_wdata),
      .st_wmask    (st_wmask),
      .ld_data     (rdata_q),
      .ld_rdata    (ld_rdata)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         addr_q         <= '0;
         size_q         <= '0;
         uns_q          <= 1'b0;
         wen_q          <= 1'b0;
         wdata_q        <= '0;
         rdata_q        <= '0;
         err_q          <= 1'b0;
         bypass_q       <= 1'b0;
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
      end else begin
         bus.resp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q  <= bus.req_addr[31:0];
                  size_q  <= bus.req_size;
                  uns_q   <= bus.req_unsigned;
                  wen_q   <= bus.req_wen;
                  wdata_q <= bus.req_wdata;
                  rdata_q <= '0;
                  // Rejected requests skip both ports and answer with an error.
                  if (bad_size || misaligned) begin
                     bypass_q <= 1'b1;
                     err_q    <= 1'b1;
                     state    <= RESP;
                  end else begin
                     bypass_q <= 1'b0;
                     err_q    <= 1'b0;
                     state    <= in_cache ? CACHE : DEV_REQ;
                  end
               end
            end
            CACHE: begin
               if (c_done) begin
                  rdata_q <= c_rdata;
                  state   <= RESP;
               end
            end
            DEV_REQ: begin
               if (d_req_ready) state <= DEV_RESP;
            end
            DEV_RESP: begin
               if (d_resp_valid) begin
                  rdata_q <= d_rdata;
                  err_q   <= d_resp_err;
                  state   <= RESP;
               end
            end
            RESP: begin
               bus.resp_valid <= 1'b1;
               bus.resp_rdata <= (wen_q | bypass_q) ? '0 : ld_rdata;
               bus.resp_err   <= err_q;
               state          <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign c_valid     = (state == CACHE);
   assign c_wen       = wen_q;
   assign c_addr      = addr_q;
   assign c_wdata     = st_wdata;
   assign c_wmask     = st_wmask;
   assign d_req_valid = (state == DEV_REQ);
   assign d_wen       = wen_q;
   assign d_addr      = addr_q;
   assign d_wdata     = st_wdata;
   assign d_wmask     = st_wmask;
   assign dbg_state   = state;

endmodule

// File: tb/tb_lsu_xbar.sv
// Directed bench for lsu_xbar: byte-lane reference model, per-cycle port and
// response checker, cache/device responders with programmable delays.
module tb_lsu_xbar;
   import lsu_pkg::*;

`ifdef LSU_MISALIGN_CHECK_EN
   localparam bit MISALIGN_CHK = 1'b1;
`else
   localparam bit MISALIGN_CHK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        c_valid, c_wen, c_done;
   logic [31:0] c_addr, d_addr;
   logic [63:0] c_wdata, c_rdata, d_wdata, d_rdata;
   logic [7:0]  c_wmask, d_wmask;
   logic        d_req_valid, d_req_ready, d_wen, d_resp_valid, d_resp_err;
   logic [2:0]  dbg_state;

   always #5 clk = ~clk;

   lsu_xbar_if #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) bus ();

   lsu_xbar dut (
      .clk (clk), .rst (rst), .bus (bus),
      .c_valid (c_valid), .c_wen (c_wen), .c_addr (c_addr), .c_wdata (c_wdata),
      .c_wmask (c_wmask), .c_rdata (c_rdata), .c_done (c_done),
      .d_req_valid (d_req_valid), .d_req_ready (d_req_ready), .d_wen (d_wen),
      .d_addr (d_addr), .d_wdata (d_wdata), .d_wmask (d_wmask),
      .d_resp_valid (d_resp_valid), .d_rdata (d_rdata), .d_resp_err (d_resp_err),
      .dbg_state (dbg_state)
   );

   // Responder configuration, set by the main sequence before each access.
   int          cache_delay = 0, ready_delay = 0, resp_delay = 0;
   logic [63:0] cache_data = '0, dev_data = '0;
   logic        dev_err = 1'b0;

   assign c_rdata    = cache_data;
   assign d_rdata    = dev_data;
   assign d_resp_err = dev_err;

   int n_checks = 0, n_errors = 0;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [63:0] model_load(input logic [63:0] data, input int off,
                                              input int size, input bit uns);
      int n = 1 << size;
      logic [63:0] r = '0;
      for (int i = 0; i < n; i++)
         if (off + i < 8) r[8*i +: 8] = data[8*(off+i) +: 8];
      if (!uns && n < 8 && r[8*n-1])
         for (int i = n; i < 8; i++) r[8*i +: 8] = 8'hFF;
      return r;
   endfunction

   function automatic void model_store(input logic [63:0] wd, input int off, input int size,
                                       output logic [63:0] ow, output logic [7:0] om);
      int n = 1 << size;
      ow = '0;
      om = '0;
      for (int i = 0; i < 8; i++) begin
         if (i >= off && i < off + n) om[i] = 1'b1;
         if (i >= off) ow[8*i +: 8] = wd[8*(i-off) +: 8];
      end
   endfunction

   typedef struct {
      int          route;   // 0 none, 1 cache, 2 device
      logic        wen;
      logic [31:0] addr;
      logic [63:0] wdata;
      logic [7:0]  wmask;
   } port_exp_t;

   port_exp_t   cur;
   bit          cur_active = 1'b0;
   logic [63:0] exp_q[$];
   logic [0:0]  exp_err_q[$];

   task automatic model_push(input logic wen, input logic [63:0] addr, input int size,
                             input bit uns, input logic [63:0] wdata);
      int  off = int'(addr[2:0]);
      bit  bad = MISALIGN_CHK && ((addr % (64'd1 << size)) != 0);
      bit  in_c = (addr[31:0] >= 32'h8000_0000) && (addr[31:0] <= 32'h87FF_FFFF);
      logic [63:0] src;
      cur.route = bad ? 0 : (in_c ? 1 : 2);
      cur.wen   = wen;
      cur.addr  = addr[31:0];
      model_store(wdata, off, size, cur.wdata, cur.wmask);
      cur_active = 1'b1;
      src = in_c ? cache_data : dev_data;
      exp_q.push_back((wen || bad) ? 64'd0 : model_load(src, off, size, uns));
      exp_err_q.push_back(bad ? 1'b1 : (cur.route == 2 ? dev_err : 1'b0));
   endtask

   // ---------------- per-cycle compare ----------------
   initial begin
      logic [63:0] e;
      logic [0:0]  ee;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (c_valid) begin
               check_eq("c_route", 64'(cur_active && cur.route == 1), 64'd1);
               check_eq("c_addr", c_addr, cur.addr);
               check_eq("c_wen", c_wen, cur.wen);
               if (cur.wen) begin
                  check_eq("c_wmask", c_wmask, cur.wmask);
                  check_eq("c_wdata", c_wdata, cur.wdata);
               end
            end
            if (d_req_valid) begin
               check_eq("d_route", 64'(cur_active && cur.route == 2), 64'd1);
               check_eq("d_addr", d_addr, cur.addr);
               check_eq("d_wen", d_wen, cur.wen);
               if (cur.wen) begin
                  check_eq("d_wmask", d_wmask, cur.wmask);
                  check_eq("d_wdata", d_wdata, cur.wdata);
               end
            end
            if (bus.resp_valid) begin
               check_eq("resp_pending", exp_q.size(), 1);
               if (exp_q.size() > 0) begin
                  e  = exp_q.pop_front();
                  ee = exp_err_q.pop_front();
                  check_eq("resp_rdata", bus.resp_rdata, e);
                  check_eq("resp_err", bus.resp_err, ee);
               end
               cur_active = 1'b0;
            end
         end
      end
   end

   // ---------------- responders ----------------
   initial begin
      int cnt = 0;
      c_done = 1'b0;
      forever begin
         @(negedge clk);
         if (c_valid) begin
            c_done = (cnt == cache_delay);
            cnt++;
         end else begin
            c_done = 1'b0;
            cnt = 0;
         end
      end
   end

   initial begin
      int rd_cnt = 0, r_cnt = 0;
      bit pending = 1'b0, prev_dv = 1'b0;
      d_req_ready  = 1'b0;
      d_resp_valid = 1'b0;
      forever begin
         @(negedge clk);
         if (d_req_ready && prev_dv) begin
            pending = 1'b1;
            r_cnt   = 0;
         end
         d_resp_valid = 1'b0;
         if (pending) begin
            if (r_cnt == resp_delay) begin
               d_resp_valid = 1'b1;
               pending = 1'b0;
            end else r_cnt++;
         end
         if (d_req_valid) begin
            d_req_ready = (rd_cnt == ready_delay);
            rd_cnt++;
         end else begin
            d_req_ready = 1'b0;
            rd_cnt = 0;
         end
         prev_dv = d_req_valid;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic issue(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                        input logic uns, input logic [63:0] wdata);
      int cnt = 0;
      @(negedge clk);
      bus.req_wen      = wen;
      bus.req_addr     = addr;
      bus.req_size     = size;
      bus.req_unsigned = uns;
      bus.req_wdata    = wdata;
      bus.req_valid    = 1'b1;
      while (!bus.req_ready && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      check_eq("req_accept", bus.req_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.req_valid = 1'b0;
      model_push(wen, addr, int'(size), uns, wdata);
   endtask

   task automatic wait_resp(input int exp_lat, output logic [63:0] rdata, output logic err);
      int lat = 0;
      do begin
         @(posedge clk);
         lat++;
         #1;
      end while (!bus.resp_valid && lat < 60);
      check_eq("resp_seen", bus.resp_valid, 1'b1);
      if (exp_lat > 0) check_eq("latency", lat, exp_lat);
      rdata = bus.resp_rdata;
      err   = bus.resp_err;
   endtask

   task automatic do_req(input logic wen, input logic [63:0] addr, input logic [1:0] size,
                         input logic uns, input logic [63:0] wdata, input int exp_lat,
                         output logic [63:0] rdata, output logic err);
      issue(wen, addr, size, uns, wdata);
      wait_resp(exp_lat, rdata, err);
   endtask

   // ---------------- main sequence ----------------
   logic [63:0] rd, mw;
   logic        er;
   logic [7:0]  mm;

   initial begin
      bus.req_valid = 1'b0; bus.req_wen = 1'b0; bus.req_addr = '0;
      bus.req_size = '0; bus.req_unsigned = 1'b0; bus.req_wdata = '0;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_eq("rst_state", dbg_state, ST_IDLE);
      check_eq("rst_req_ready", bus.req_ready, 1'b1);
      check_eq("rst_resp_valid", bus.resp_valid, 1'b0);
      check_eq("rst_resp_rdata", bus.resp_rdata, 64'd0);
      check_eq("rst_resp_err", bus.resp_err, 1'b0);
      check_eq("rst_c_valid", c_valid, 1'b0);
      check_eq("rst_d_req_valid", d_req_valid, 1'b0);
      rst = 1'b0;

      // Pin the model with hand-computed values.
      check_eq("pin_ld_w", model_load(64'h8000_0001_0000_0000, 4, 2, 0), 64'hFFFF_FFFF_8000_0001);
      check_eq("pin_ld_b", model_load(64'h0000_0000_FF00_0000, 3, 0, 1), 64'h0000_0000_0000_00FF);
      check_eq("pin_ld_trunc", model_load(64'hAB00_0000_0000_0000, 7, 1, 1), 64'h0000_0000_0000_00AB);
      model_store(64'h1234, 6, 1, mw, mm);
      check_eq("pin_st_wdata", mw, 64'h1234_0000_0000_0000);
      check_eq("pin_st_wmask", mm, 8'hC0);

      // Signed word load from the cache, done in first cycle.
      cache_delay = 0;
      cache_data  = 64'h8000_0001_0000_0000;
      do_req(1'b0, 64'h8000_0004, SZ_W, 1'b0, 64'd0, 2, rd, er);
      check_eq("ld_w_cache_rdata", rd, 64'hFFFF_FFFF_8000_0001);
      check_eq("ld_w_cache_err", er, 1'b0);

      // Halfword store to the device with ready delayed 3 cycles.
      ready_delay = 3; resp_delay = 0; dev_err = 1'b0;
      fork
         do_req(1'b1, 64'hA000_0006, SZ_H, 1'b0, 64'h1234, 6, rd, er);
         begin
            int k = 0;
            while (!d_req_valid && k < 20) begin
               @(negedge clk);
               k++;
            end
            check_eq("st_h_dreq_seen", d_req_valid, 1'b1);
            check_eq("st_h_wmask", d_wmask, 8'hC0);
            check_eq("st_h_wdata", d_wdata, 64'h1234_0000_0000_0000);
         end
      join
      check_eq("st_h_rdata", rd, 64'd0);

      // Unsigned byte load from the device with an error response.
      ready_delay = 0; resp_delay = 0;
      dev_data = 64'h0000_0000_FF00_0000; dev_err = 1'b1;
      do_req(1'b0, 64'h1000_0003, SZ_B, 1'b1, 64'd0, 3, rd, er);
      check_eq("ld_b_dev_rdata", rd, 64'h0000_0000_0000_00FF);
      check_eq("ld_b_dev_err", er, 1'b1);

      // Signed byte load from the device, delayed ready and response.
      ready_delay = 1; resp_delay = 2;
      dev_data = 64'h0000_8000_0000_0000; dev_err = 1'b0;
      do_req(1'b0, 64'h4000_0005, SZ_B, 1'b0, 64'd0, 6, rd, er);
      check_eq("ld_b_sext_rdata", rd, 64'hFFFF_FFFF_FFFF_FF80);

      // Byte store and signed halfword load through the cache.
      cache_delay = 2;
      do_req(1'b1, 64'h8000_0013, SZ_B, 1'b0, 64'hAB, 4, rd, er);
      cache_delay = 0;
      cache_data  = 64'h0000_0000_8765_0000;
      do_req(1'b0, 64'h8000_0102, SZ_H, 1'b0, 64'd0, 2, rd, er);
      check_eq("ld_h_sext_rdata", rd, 64'hFFFF_FFFF_FFFF_8765);

      // Accesses crossing or misaligned within the word.
      cache_data = 64'hAB00_0000_0000_0000;
      do_req(1'b0, 64'h8000_0007, SZ_H, 1'b1, 64'd0, MISALIGN_CHK ? 1 : 2, rd, er);
      cache_data = 64'h1122_3344_5566_7788;
      do_req(1'b0, 64'h8000_0004, SZ_D, 1'b0, 64'd0, MISALIGN_CHK ? 1 : 2, rd, er);
      check_eq("ld_d_mis_err", er, MISALIGN_CHK);

      // Doubleword store to the device.
      ready_delay = 0; resp_delay = 1;
      do_req(1'b1, 64'h2000_0008, SZ_D, 1'b0, 64'h0123_4567_89AB_CDEF, 4, rd, er);

      // Window boundaries, including an address above 32 bits.
      cache_data = 64'h0000_0000_DEAD_BEEF;
      dev_data   = 64'h0000_0000_CAFE_F00D;
      resp_delay = 0;
      do_req(1'b0, 64'h87FF_FFF8, SZ_W, 1'b1, 64'd0, 2, rd, er);
      do_req(1'b0, 64'h8800_0000, SZ_W, 1'b1, 64'd0, 3, rd, er);
      do_req(1'b0, 64'h7FFF_FFF8, SZ_W, 1'b1, 64'd0, 3, rd, er);
      do_req(1'b0, 64'h8000_0000, SZ_W, 1'b0, 64'd0, 2, rd, er);
      do_req(1'b0, 64'h1_8000_0000, SZ_W, 1'b1, 64'd0, 2, rd, er);
      check_eq("hi_addr_cache_rdata", rd, 64'h0000_0000_DEAD_BEEF);

      // Back-to-back requests with req_valid held high.
      cache_delay = 0;
      @(negedge clk);
      bus.req_wen = 1'b0; bus.req_addr = 64'h8000_0000; bus.req_size = SZ_W;
      bus.req_unsigned = 1'b1; bus.req_wdata = '0; bus.req_valid = 1'b1;
      @(posedge clk);
      #1;
      model_push(1'b0, 64'h8000_0000, SZ_W, 1'b1, 64'd0);
      bus.req_wen = 1'b1; bus.req_addr = 64'h8000_0010; bus.req_wdata = 64'h5555_AAAA;
      @(negedge clk);
      check_eq("b2b_ready_cache", bus.req_ready, 1'b0);
      @(negedge clk);
      check_eq("b2b_ready_resp", bus.req_ready, 1'b0);
      @(negedge clk);
      check_eq("b2b_ready_idle", bus.req_ready, 1'b1);
      check_eq("b2b_resp1", bus.resp_valid, 1'b1);
      @(posedge clk);
      #1;
      model_push(1'b1, 64'h8000_0010, SZ_W, 1'b1, 64'h5555_AAAA);
      bus.req_valid = 1'b0;
      wait_resp(2, rd, er);

      // Reset while waiting for a device response; the late response is dropped.
      ready_delay = 0; resp_delay = 4;
      issue(1'b0, 64'h3000_0000, SZ_W, 1'b0, 64'd0);
      begin
         int k = 0;
         while (dbg_state != ST_DEV_RESP && k < 20) begin
            @(negedge clk);
            k++;
         end
      end
      check_eq("rst_mid_state", dbg_state, ST_DEV_RESP);
      rst = 1'b1;
      exp_q.delete();
      exp_err_q.delete();
      cur_active = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      repeat (8) begin
         @(negedge clk);
         check_eq("no_resp_after_rst", bus.resp_valid, 1'b0);
      end
      check_eq("post_rst_state", dbg_state, ST_IDLE);
      check_eq("post_rst_ready", bus.req_ready, 1'b1);

      // Normal traffic resumes.
      resp_delay = 0;
      dev_data = 64'h0000_0000_0000_7F01;
      do_req(1'b0, 64'h3000_0000, SZ_H, 1'b0, 64'd0, 3, rd, er);
      check_eq("post_rst_rdata", rd, 64'h0000_0000_0000_7F01);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/lsu_xbar.md
LSU_XBAR -- requirements
Module: lsu_xbar

Interface
REQ-001 Param ADDR_WIDTH, 64, request address width.
REQ-002 Param DATA_WIDTH, 64, data width; legal values 32 or 64; STRB = DATA_WIDTH/8.
REQ-003 Param CACHE_BASE, 32'h8000_0000, lowest cached address (compared on addr[31:0]).
REQ-004 Param CACHE_LIMIT, 32'h87FF_FFFF, highest cached address, inclusive.
REQ-005 Clock and reset: one clock, clk; reset rst, synchronous, active-high.
REQ-006 clk  in  1  clock.
REQ-007 rst  in  1  synchronous active-high reset.
REQ-008 req_valid/req_ready  in/out  1  request handshake; transfer when both are high on a rising edge.
REQ-009 req_wen  in  1  1 = store, 0 = load.
REQ-010 req_addr  in  ADDR_WIDTH  byte address.
REQ-011 req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D.
REQ-012 req_unsigned  in  1  zero-extend loads when 1, sign-extend when 0.
REQ-013 req_wdata  in  DATA_WIDTH  store data, right-aligned in the low bytes.
REQ-014 resp_valid  out  1  one-cycle completion pulse; resp_rdata  out  DATA_WIDTH  extended load data; resp_err  out  1  error flag.
REQ-015 Cache port: c_valid out 1, c_wen out 1, c_addr out 32, c_wdata out DATA_WIDTH, c_wmask out STRB, c_rdata in DATA_WIDTH, c_done in 1.
REQ-016 Device port: d_req_valid out 1, d_req_ready in 1, d_wen out 1, d_addr out 32, d_wdata out DATA_WIDTH, d_wmask out STRB, d_resp_valid in 1, d_rdata in DATA_WIDTH, d_resp_err in 1.

Function
REQ-017 req_ready SHALL be 1 only in state IDLE; on acceptance, addr, size, unsigned, wen and wdata SHALL be latched.
REQ-018 Routing SHALL go to the cache when CACHE_BASE <= addr[31:0] <= CACHE_LIMIT, and to the device port otherwise.
REQ-019 FSM states SHALL be IDLE, CACHE, DEV_REQ, DEV_RESP, RESP.
REQ-020 Transitions: IDLE->CACHE or DEV_REQ on accept; CACHE->RESP on c_done; DEV_REQ->DEV_RESP on d_req_ready; DEV_RESP->RESP on d_resp_valid; RESP->IDLE unconditionally.
REQ-021 c_valid SHALL be high throughout CACHE; d_req_valid SHALL be high throughout DEV_REQ; their addr/data/mask SHALL be held stable.
REQ-022 Byte offset off = addr[log2(STRB)-1:0]; store wmask = ((1<<2^size)-1) << off, truncated to STRB bits; wdata = req_wdata << (8*off).
REQ-023 Load path: captured data >> (8*off), then sign/zero-extend from bit 8*2^size-1; size D passes through unchanged.
REQ-024 Stores SHALL return resp_rdata = 0; resp_err SHALL equal d_resp_err captured in DEV_RESP, and SHALL be 0 for cache accesses.
REQ-025 Best-case latency (accept edge to resp_valid): cache with c_done in the first CACHE cycle = 2 cycles; device with ready and response each in their first cycle = 3 cycles.
REQ-026 d_resp_valid SHALL be ignored outside DEV_RESP; c_done SHALL be ignored outside CACHE.
REQ-027 With DATA_WIDTH = 32, size 3 SHALL go directly IDLE->RESP with resp_err = 1 and no port activity.

Reset
REQ-028 On rst: state = IDLE; c_valid, d_req_valid, resp_valid, resp_err = 0; resp_rdata = 0; latched fields = 0.
REQ-029 A reset mid-transaction SHALL abandon it with no response; a late device response after reset SHALL be dropped per REQ-026.

Configuration
REQ-030 LSU_MISALIGN_CHECK_EN defined: if addr is not a multiple of 2^size, the request SHALL go IDLE->RESP with resp_err = 1, resp_rdata = 0 and no port activity.
REQ-031 LSU_MISALIGN_CHECK_EN undefined: no check is made, and bytes beyond the word boundary SHALL be truncated per REQ-022.

Structure
REQ-032 Package lsu_pkg SHALL hold the size encoding, the FSM state enum, and the default CACHE_BASE/CACHE_LIMIT constants.
REQ-033 One combinational sub-module, lsu_align, SHALL perform store shift, mask generation and load shift/extend; the FSM and routing SHALL stay in lsu_xbar.

Verification
REQ-034 Load W, signed, addr 0x8000_0004, c_rdata 0x8000_0001_0000_0000, c_done in first cycle -> resp_rdata 0xFFFF_FFFF_8000_0001 exactly 2 cycles after accept.
REQ-035 Store H, addr 0xA000_0006, wdata 0x1234, d_req_ready delayed 3 cycles -> d_wmask 0xC0, d_wdata 0x1234_0000_0000_0000, held stable until ready.
REQ-036 Load B, unsigned, device, d_rdata 0xFF in byte 3, addr 0x1000_0003, d_resp_err = 1 -> resp_rdata 0xFF, resp_err = 1.
REQ-037 With LSU_MISALIGN_CHECK_EN: load D at 0x8000_0004 -> resp_err = 1 one cycle after accept, c_valid never asserted; without the macro -> cache access issued.
REQ-038 rst asserted in DEV_RESP, then d_resp_valid pulsed -> no resp_valid, state IDLE, req_ready = 1.
REQ-039 Back-to-back requests with req_valid held high -> req_ready low from accept through RESP, second request accepted the cycle after RESP.
